// File: rtl/logic_op_sequencer_if.sv
// Host-side bundle for logic_op_sequencer: program table writes, run control
// and the z result. The master drives the host side and the slave is the sequencer.
interface logic_op_sequencer_if #(
  parameter int WIDTH  = 1,
  parameter int NSTEPS = 4,
  parameter int DLY_W  = 8
);
  localparam int AW = $clog2(NSTEPS);

  logic             prog_we;
  logic [AW-1:0]    prog_addr;
  logic [1:0]       prog_op;
  logic [DLY_W-1:0] prog_dly;
  logic [WIDTH-1:0] prog_arg;
  logic [AW:0]      prog_len;
  logic [WIDTH-1:0] x_init;
  logic [WIDTH-1:0] y_init;
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] z;
  logic             z_chg;
  logic [AW-1:0]    step_idx;

  modport master (
    output prog_we, prog_addr, prog_op, prog_dly, prog_arg, prog_len,
           x_init, y_init, start, abort,
    input  busy, done, z, z_chg, step_idx
  );

  modport slave (
    input  prog_we, prog_addr, prog_op, prog_dly, prog_arg, prog_len,
           x_init, y_init, start, abort,
    output busy, done, z, z_chg, step_idx
  );
endinterface

// File: rtl/logic_op_sequencer.sv
// Timed program sequencer over a small bitwise datapath (z = x^y, x|y, ~z; SETY loads y).
// A registered z_chg strobe marks every edge on which z took a new value.
module logic_op_sequencer #(
  parameter int WIDTH  = 1,
  parameter int NSTEPS = 4,
  parameter int DLY_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  logic_op_sequencer_if.slave  bus
);
  localparam int AW = $clog2(NSTEPS);
  localparam int LW = AW + 1;

  localparam logic [1:0] OP_XOR  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_NOT  = 2'b10;
  localparam logic [1:0] OP_SETY = 2'b11;

  typedef enum logic {IDLE, RUN} state_e;

  logic [1:0]       op_q  [NSTEPS];
  logic [DLY_W-1:0] dly_q [NSTEPS];
  logic [WIDTH-1:0] arg_q [NSTEPS];

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic             z_chg_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] z_q;
  logic [DLY_W-1:0] cnt_q;
  logic [AW-1:0]    idx_q;
  logic [LW-1:0]    len_q;

  logic [WIDTH-1:0] z_d;
  logic [WIDTH-1:0] y_d;
  logic [AW-1:0]    idx_d;
  logic [LW-1:0]    len_d;
  logic             last_step;

  // Program table is writable only while idle, so a running program is frozen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NSTEPS; i++) begin
        op_q[i]  <= OP_XOR;
        dly_q[i] <= '0;
        arg_q[i] <= '0;
      end
    end else if (bus.prog_we && !busy_q) begin
      op_q[bus.prog_addr]  <= bus.prog_op;
      dly_q[bus.prog_addr] <= bus.prog_dly;
      arg_q[bus.prog_addr] <= bus.prog_arg;
    end
  end

  always_comb begin
    z_d = z_q;
    y_d = y_q;
    unique case (op_q[idx_q])
      OP_XOR:  z_d = x_q ^ y_q;
      OP_OR:   z_d = x_q | y_q;
      OP_NOT:  z_d = ~z_q;
      OP_SETY: y_d = arg_q[idx_q];
    endcase
    idx_d     = idx_q + AW'(1);
    len_d     = (bus.prog_len > LW'(NSTEPS)) ? LW'(NSTEPS) : bus.prog_len;
    last_step = ({1'b0, idx_q} == (len_q - LW'(1)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      z_chg_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
    end else begin
      done_q  <= 1'b0;
      z_chg_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            x_q   <= bus.x_init;
            y_q   <= bus.y_init;
            idx_q <= '0;
            cnt_q <= dly_q[0];
            len_q <= len_d;
            // An empty program completes immediately without ever raising busy.
            if (len_d == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DLY_W'(1);
          end else begin
            z_q     <= z_d;
            y_q     <= y_d;
            z_chg_q <= (z_d != z_q);
            if (last_step) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_d;
              cnt_q <= dly_q[idx_d];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.z        = z_q;
  assign bus.z_chg    = z_chg_q;
  assign bus.step_idx = idx_q;
endmodule

// File: tb/tb_logic_op_sequencer.sv
// Randomised and directed bench for logic_op_sequencer against a timeline model
// built from each program's cumulative step delays.
module tb_logic_op_sequencer;
  localparam int W  = 1;
  localparam int NS = 4;
  localparam int DW = 8;
  localparam int AW = $clog2(NS);
  localparam int LW = AW + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic_op_sequencer_if #(.WIDTH(W), .NSTEPS(NS), .DLY_W(DW)) bus ();

  logic_op_sequencer #(.WIDTH(W), .NSTEPS(NS), .DLY_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int run_no = 0;

  int           m_op  [NS];
  int           m_dly [NS];
  logic [W-1:0] m_arg [NS];
  logic [W-1:0] m_z;
  int           m_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_table_reset();
    for (int i = 0; i < NS; i++) begin
      m_op[i]  = 0;
      m_dly[i] = 0;
      m_arg[i] = '0;
    end
  endtask

  task automatic prog(input int a, input int op, input int d, input logic [W-1:0] arg);
    bus.prog_we   = 1'b1;
    bus.prog_addr = AW'(a);
    bus.prog_op   = 2'(op);
    bus.prog_dly  = DW'(d);
    bus.prog_arg  = arg;
    @(negedge clk);
    bus.prog_we = 1'b0;
    m_op[a]  = op;
    m_dly[a] = d;
    m_arg[a] = arg;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle.busy", 32'(bus.busy), 32'(0));
      check("idle.done", 32'(bus.done), 32'(0));
      check("idle.zchg", 32'(bus.z_chg), 32'(0));
      check("idle.z", 32'(bus.z), 32'(m_z));
      check("idle.idx", 32'(bus.step_idx), 32'(m_idx));
    end
  endtask

  // Sample n is taken at the negedge following edge E0+n (E0 = start accepted).
  task automatic run(input int len_i, input logic [W-1:0] xi, input logic [W-1:0] yi,
                     input int cut, input bit cut_rst, input bit noise, input bit abort_at_start);
    int           e  [NS];
    logic [W-1:0] zk [NS];
    bit           ck [NS];
    int           L, T, stop, t, eidx;
    bit           aborted, echg, ebusy, edone, inc;
    logic [W-1:0] zc, yc, ez;
    string        pfx;

    run_no++;
    L  = (len_i > NS) ? NS : len_i;
    zc = m_z;
    yc = yi;
    t  = 0;
    for (int k = 0; k < L; k++) begin
      t += m_dly[k] + 1;
      e[k] = t;
      case (m_op[k])
        0:       zk[k] = xi ^ yc;
        1:       zk[k] = xi | yc;
        2:       zk[k] = ~zc;
        default: begin zk[k] = zc; yc = m_arg[k]; end
      endcase
      ck[k] = (zk[k] != zc);
      zc = zk[k];
    end
    T       = (L == 0) ? 0 : e[L-1];
    aborted = (cut > 0) && (L > 0) && (cut <= T);
    stop    = aborted ? cut : T;

    bus.start    = 1'b1;
    bus.x_init   = xi;
    bus.y_init   = yi;
    bus.prog_len = LW'(len_i);
    bus.abort    = abort_at_start;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;

    ez = m_z;
    eidx = 0;
    for (int n = 0; n <= stop; n++) begin
      if (n > 0) @(negedge clk);
      pfx = $sformatf("r%0d.n%0d", run_no, n);
      ez = m_z;
      eidx = 0;
      echg = 1'b0;
      for (int k = 0; k < L; k++) begin
        inc = (e[k] <= n) && !(aborted && e[k] >= stop);
        if (inc) begin
          ez = zk[k];
          if (k < L - 1) eidx = k + 1;
          if (e[k] == n) echg = ck[k];
        end
      end
      ebusy = (L > 0) && (n < stop);
      edone = !aborted && (n == T);
      if (aborted && cut_rst && n == stop) begin
        ez = '0;
        eidx = 0;
      end
      check({pfx, ".z"},    32'(bus.z),        32'(ez));
      check({pfx, ".zchg"}, 32'(bus.z_chg),    32'(echg));
      check({pfx, ".busy"}, 32'(bus.busy),     32'(ebusy));
      check({pfx, ".done"}, 32'(bus.done),     32'(edone));
      check({pfx, ".idx"},  32'(bus.step_idx), 32'(eidx));

      bus.start   = 1'b0;
      bus.prog_we = 1'b0;
      bus.abort   = 1'b0;
      if (noise && n < stop) begin
        bus.start     = 1'($urandom_range(0, 1));
        bus.prog_we   = 1'($urandom_range(0, 1));
        bus.prog_addr = AW'($urandom_range(0, NS - 1));
        bus.prog_op   = 2'($urandom_range(0, 3));
        bus.prog_dly  = DW'($urandom_range(0, 20));
        bus.prog_arg  = W'($urandom);
        bus.x_init    = W'($urandom);
        bus.y_init    = W'($urandom);
      end
      if (aborted && n == stop - 1) begin
        if (cut_rst) rst_n = 1'b0;
        else bus.abort = 1'b1;
      end
      if (n == stop) rst_n = 1'b1;
    end

    if (aborted && cut_rst) begin
      m_z = '0;
      m_idx = 0;
      model_table_reset();
    end else begin
      m_z = ez;
      m_idx = eidx;
    end
  endtask

  task automatic prog_basic();
    prog(0, 0, 1, '0);
    prog(1, 3, 9, '0);
    prog(2, 1, 0, '0);
    prog(3, 2, 9, '0);
  endtask

  initial begin
    int len, cut;
    bit crst;
    rst_n         = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_op   = '0;
    bus.prog_dly  = '0;
    bus.prog_arg  = '0;
    bus.prog_len  = '0;
    bus.x_init    = '0;
    bus.y_init    = '0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    model_table_reset();
    m_z = '0;
    m_idx = 0;

    repeat (3) @(negedge clk);
    check("rst.busy", 32'(bus.busy), 32'(0));
    check("rst.done", 32'(bus.done), 32'(0));
    check("rst.z", 32'(bus.z), 32'(0));
    check("rst.zchg", 32'(bus.z_chg), 32'(0));
    check("rst.idx", 32'(bus.step_idx), 32'(0));
    rst_n = 1'b1;
    idle(1);

    prog_basic();
    run(4, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    idle(2);
    run(4, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
    idle(3);
    run(4, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    idle(1);
    run(4, 1'b0, 1'b1, 23, 1'b0, 1'b0, 1'b0);
    idle(2);
    run(4, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    run(4, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    idle(1);
    run(0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    idle(1);
    run(7, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    idle(1);
    run(4, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    idle(1);

    prog(0, 0, 0, '0);
    prog(1, 2, 0, '0);
    prog(2, 2, 0, '0);
    run(1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    idle(1);
    run(3, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    idle(1);

    prog(0, 0, 255, '0);
    run(1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    idle(1);

    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int a = 0; a < NS; a++)
          prog(a, $urandom_range(0, 3),
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 2),
               W'($urandom));
      end
      idle($urandom_range(0, 2));
      len  = $urandom_range(0, 7);
      cut  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
      crst = (cut > 0) && ($urandom_range(0, 5) == 0);
      run(len, W'($urandom), W'($urandom), cut, crst,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(2);

    prog_basic();
    idle(1);
    run(4, 1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0);
    idle(1);
    run(1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
